seg_display_scheduler: RTL and testbench
========================================

Name: seg_display_scheduler

Overview:
Time-shares the single six-digit 7-segment readout between N_SRC debug/status sources of the adaptive-thresholding pipeline, such as threshold, pixel count and frame count. Each source's latest 24-bit value is captured on its valid strobe. The block rotates through enabled sources automatically after a programmable dwell or on a manual advance pulse. Its registered disp_value drives the hex decoder directly; disp_sel drives LEDs to identify the source shown.

Parameters:
N_SRC, 4, number of requesting sources (2..8)
DWELL, 50000000, cycles each source is shown in auto mode (>=2)
SEL_W, 2, width of source index, equal to clog2(N_SRC)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
src_value  in  24*N_SRC  packed source values; source i is bits [24*i+23:24*i]
src_valid  in  N_SRC  per-source capture strobe
src_enable  in  N_SRC  source participates in rotation
mode_auto  in  1  1 = dwell-timed rotation; 0 = manual only
next_pulse  in  1  single-cycle advance request (already debounced)
freeze  in  1  hold captures, rotation and dwell counter
disp_value  out  24  value sent to the 7-seg decoder
disp_sel  out  SEL_W  index of the source shown
disp_blank  out  1  no source enabled; disp_value is 0
disp_new  out  1  one-cycle pulse when disp_sel changes

Behaviour:
- Reset: all cap[i]=0, sel=0, dwell_cnt=0, disp_value=0, disp_sel=0, disp_new=0.
  - disp_blank=1 after reset and stays 1 until the first cycle after reset where src_enable!=0.
- Capture: each cycle, for each i with src_valid[i]=1 and freeze=0, cap[i] <= src_value slice i. freeze=1 blocks the capture.
- FSM has two states, BLANK and SHOW.
  - BLANK: entered when src_enable==0. disp_blank=1 and disp_value=0; sel holds its value.
  - BLANK -> SHOW: when any enable is set, sel <= first enabled index searched upward from sel inclusive, wrapping. disp_new pulses if sel changes.
  - SHOW -> BLANK: when src_enable==0.
- Advance event, SHOW state only, freeze=0:
  - Sources: next_pulse=1, or mode_auto=1 with dwell_cnt==DWELL-1, or src_enable[sel]==0 while another source is enabled.
  - Simultaneous sources produce one advance, never two.
  - Search: sel <= next enabled index after sel, scanning upward and wrapping modulo N_SRC.
  - If sel is the only enabled source, sel is unchanged and disp_new=0.
  - Any advance resets dwell_cnt to 0.
- Dwell counter:
  - Counts 0..DWELL-1 in SHOW with mode_auto=1 and freeze=0.
  - Held at 0 when mode_auto=0 or in BLANK.
  - Holds its value while freeze=1.
  - Switching mode_auto 0->1 starts the count from 0.
- Freeze: next_pulse is ignored, not queued. Disabling the current source during freeze defers the advance until freeze deasserts.
- Output timing:
  - disp_value <= (BLANK ? 0 : cap[sel_next]), registered.
  - disp_value reflects a new sel one cycle after the advance event.
  - disp_value reflects a new capture on the shown source one cycle after src_valid, i.e. the same edge the capture is registered.
  - disp_sel tracks sel and is registered on the same edge as disp_value.
  - disp_new=1 for exactly the cycle in which disp_sel first shows the new index.
- src_valid on a source not currently shown updates only cap[i]; disp_value is unchanged.
- rst mid-dwell or mid-advance returns all state to the reset values on the next edge; pending advances are discarded.

Test Plan:
- Reset, then src_enable=4'b1111, mode_auto=1, DWELL=4, cap = {0x000001, 0x000002, 0x000003, 0x000004} -> disp_sel sequence 0,1,2,3,0 with a change every 4 cycles; disp_value tracks; disp_new pulses once per change.
- mode_auto=0, src_enable=4'b1010, sel=1: next_pulse -> disp_sel=3 one cycle later; next_pulse again -> disp_sel=1, wrapping and skipping 0 and 2.
- Shown source 2 receives src_valid with 0xABCDEF -> disp_value=0xABCDEF one cycle later. src_valid on source 0 with 0x123456 -> disp_value unchanged.
- freeze=1 with src_valid[2] carrying 0x111111, plus next_pulse and an expired dwell -> disp_value, disp_sel and dwell_cnt unchanged. On release, rotation resumes from the held count.
- Clear src_enable[sel] while 4'b0101 is enabled and sel=2 -> disp_sel=0 within 2 cycles. Then src_enable=0 -> disp_blank=1, disp_value=0. Re-enable bit 2 -> disp_sel=2, disp_blank=0.
- Assert rst mid-dwell with dwell_cnt=2 and sel=3 -> next cycle disp_sel=0, disp_value=0, disp_new=0. After rst deasserts with sources enabled, a full DWELL elapses before the first advance.

Source files
------------

// File: rtl/seg_display_scheduler.sv
// -----------------------------------------------------------------------------
// seg_display_scheduler
//
// Time-shares one six-digit 7-segment readout between N_SRC status sources.
// Each source's latest 24-bit value is captured on its valid strobe. The shown
// source rotates through the enabled set, either after DWELL cycles (auto mode)
// or on a manual advance pulse. All outputs are registered.
//
// Ports:
//   clk         system clock
//   rst         synchronous reset, active-high
//   src_value   packed source values, source i in bits [24*i+23:24*i]
//   src_valid   per-source capture strobe
//   src_enable  per-source participation in the rotation
//   mode_auto   1 = dwell-timed rotation, 0 = manual advance only
//   next_pulse  single-cycle advance request (already debounced)
//   freeze      holds captures, rotation and the dwell counter
//   disp_value  value for the 7-segment decoder (0 while blank)
//   disp_sel    index of the source currently shown
//   disp_blank  no source enabled
//   disp_new    one-cycle pulse in the first cycle disp_sel shows a new index
// -----------------------------------------------------------------------------
module seg_display_scheduler #(
  parameter int N_SRC = 4,
  parameter int DWELL = 50000000,
  parameter int SEL_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [24*N_SRC-1:0]   src_value,
  input  logic [N_SRC-1:0]      src_valid,
  input  logic [N_SRC-1:0]      src_enable,
  input  logic                  mode_auto,
  input  logic                  next_pulse,
  input  logic                  freeze,
  output logic [23:0]           disp_value,
  output logic [SEL_W-1:0]      disp_sel,
  output logic                  disp_blank,
  output logic                  disp_new
);

  localparam int DW_W = (DWELL > 2) ? $clog2(DWELL) : 1;
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  state_t            state_r;
  state_t            state_next_s;
  logic [SEL_W-1:0]  sel_r;
  logic [SEL_W-1:0]  sel_next_s;
  logic [DW_W-1:0]   dwell_cnt_r;
  logic [DW_W-1:0]   dwell_next_s;
  logic [23:0]       cap_r      [N_SRC];
  logic [23:0]       cap_next_s [N_SRC];
  logic              any_en_s;
  logic              expire_s;
  logic              adv_s;

  // Returns the first enabled index at or after start (incl=1) or strictly
  // after start (incl=0), wrapping modulo N_SRC. In the exclusive search the
  // last offset examined is start itself, so a lone enabled source maps back
  // onto itself and the selection does not change.
  function automatic logic [SEL_W-1:0] find_enabled(
    input logic [N_SRC-1:0] en,
    input logic [SEL_W-1:0] start,
    input logic             incl
  );
    logic [SEL_W-1:0] res;
    logic [SEL_W-1:0] idx;
    logic             found;
    int               off;
    int               tmp;
    res   = start;
    found = 1'b0;
    off   = incl ? 32'sd0 : 32'sd1;
    for (int k = 0; k < N_SRC; k++) begin
      tmp = int'(start) + k + off;
      if (tmp >= N_SRC) begin
        tmp = tmp - N_SRC;
      end else begin
        tmp = tmp;
      end
      idx = SEL_W'(tmp);
      if (!found && en[idx]) begin
        res   = idx;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return res;
  endfunction

  // Next capture value per source; freeze blocks every capture.
  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      if (src_valid[i] && !freeze) begin
        cap_next_s[i] = src_value[24*i +: 24];
      end else begin
        cap_next_s[i] = cap_r[i];
      end
    end
  end

  // Capture registers for the latest value of each source.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_SRC; i++) begin
        cap_r[i] <= 24'h000000;
      end
    end else begin
      for (int i = 0; i < N_SRC; i++) begin
        cap_r[i] <= cap_next_s[i];
      end
    end
  end

  // Next state, advance decision and next selection.
  always_comb begin
    any_en_s     = |src_enable;
    expire_s     = mode_auto && (dwell_cnt_r == DWELL_LAST);
    adv_s        = 1'b0;
    sel_next_s   = sel_r;
    state_next_s = any_en_s ? ST_SHOW : ST_BLANK;
    if (!any_en_s) begin
      // Blanking keeps the last selection so re-enabling resumes there.
      sel_next_s = sel_r;
    end else if (state_r == ST_BLANK) begin
      sel_next_s = find_enabled(src_enable, sel_r, 1'b1);
    end else if (!freeze && (next_pulse || expire_s || !src_enable[sel_r])) begin
      // All advance causes collapse into a single step.
      adv_s      = 1'b1;
      sel_next_s = find_enabled(src_enable, sel_r, 1'b0);
    end else begin
      sel_next_s = sel_r;
    end
  end

  // Dwell counter next value. mode_auto=0 forces zero ahead of freeze so a
  // 0->1 mode switch always starts a full dwell.
  always_comb begin
    dwell_next_s = dwell_cnt_r;
    if ((state_r == ST_BLANK) || !any_en_s) begin
      dwell_next_s = {DW_W{1'b0}};
    end else if (!mode_auto) begin
      dwell_next_s = {DW_W{1'b0}};
    end else if (freeze) begin
      dwell_next_s = dwell_cnt_r;
    end else if (adv_s) begin
      dwell_next_s = {DW_W{1'b0}};
    end else begin
      dwell_next_s = dwell_cnt_r + {{(DW_W-1){1'b0}}, 1'b1};
    end
  end

  // FSM state, selection, dwell counter and registered display outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_BLANK;
      sel_r       <= {SEL_W{1'b0}};
      dwell_cnt_r <= {DW_W{1'b0}};
      disp_value  <= 24'h000000;
      disp_sel    <= {SEL_W{1'b0}};
      disp_blank  <= 1'b1;
      disp_new    <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      sel_r       <= sel_next_s;
      dwell_cnt_r <= dwell_next_s;
      disp_sel    <= sel_next_s;
      disp_new    <= (sel_next_s != sel_r);
      disp_blank  <= (state_next_s == ST_BLANK);
      // Reading the next capture value lets a fresh capture on the shown
      // source appear on the same edge that registers it.
      case (state_next_s)
        ST_BLANK: disp_value <= 24'h000000;
        ST_SHOW:  disp_value <= cap_next_s[sel_next_s];
        default:  disp_value <= 24'h000000;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_display_scheduler.sv
// -----------------------------------------------------------------------------
// tb_seg_display_scheduler
//
// Directed bench for seg_display_scheduler (N_SRC=4, DWELL=4). Inputs are
// driven 1 time unit after each rising edge and outputs are sampled at the
// same point, i.e. they reflect the edge just taken.
// -----------------------------------------------------------------------------
module tb_seg_display_scheduler;

  logic        clk;
  logic        rst;
  logic [95:0] src_value;
  logic [3:0]  src_valid;
  logic [3:0]  src_enable;
  logic        mode_auto;
  logic        next_pulse;
  logic        freeze;
  logic [23:0] disp_value;
  logic [1:0]  disp_sel;
  logic        disp_blank;
  logic        disp_new;

  int n_total;
  int n_pass;

  seg_display_scheduler #(
    .N_SRC (4),
    .DWELL (4),
    .SEL_W (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .src_value  (src_value),
    .src_valid  (src_valid),
    .src_enable (src_enable),
    .mode_auto  (mode_auto),
    .next_pulse (next_pulse),
    .freeze     (freeze),
    .disp_value (disp_value),
    .disp_sel   (disp_sel),
    .disp_blank (disp_blank),
    .disp_new   (disp_new)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic expect_disp(input string tag, input int sel, input int val,
                             input int blank, input int nw);
    chk({tag, ".sel"},   32'(disp_sel),   32'(sel));
    chk({tag, ".value"}, 32'(disp_value), 32'(val));
    chk({tag, ".blank"}, 32'(disp_blank), 32'(blank));
    chk({tag, ".new"},   32'(disp_new),   32'(nw));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_next();
    next_pulse = 1'b1;
    step();
    next_pulse = 1'b0;
  endtask

  initial begin
    n_total    = 0;
    n_pass     = 0;
    rst        = 1'b1;
    src_value  = 96'h0;
    src_valid  = 4'b0000;
    src_enable = 4'b0000;
    mode_auto  = 1'b0;
    next_pulse = 1'b0;
    freeze     = 1'b0;
    step();
    step();
    expect_disp("reset", 0, 24'h000000, 1, 0);

    // Load caps with i+1 while nothing is enabled: display stays blank.
    rst = 1'b0;
    for (int i = 0; i < 4; i++) src_value[24*i +: 24] = 24'(i + 1);
    src_valid = 4'b1111;
    step();
    expect_disp("load_blank", 0, 24'h000000, 1, 0);
    src_valid = 4'b0000;

    // Auto rotation: first enable shows source 0, then a change every 4 cycles.
    src_enable = 4'b1111;
    mode_auto  = 1'b1;
    step();
    expect_disp("first_show", 0, 24'h000001, 0, 0);
    for (int s = 1; s <= 4; s++) begin
      for (int c = 0; c < 3; c++) begin
        step();
        chk("auto_hold.sel", 32'(disp_sel), 32'((s - 1) % 4));
        chk("auto_hold.new", 32'(disp_new), 32'd0);
      end
      step();
      expect_disp("auto_adv", s % 4, (s % 4) + 1, 0, 1);
    end

    // Manual mode with 1010: disabling shown source 0 moves to 1, then pulses wrap.
    mode_auto  = 1'b0;
    src_enable = 4'b1010;
    step();
    expect_disp("disable_cur", 1, 24'h000002, 0, 1);
    step();
    expect_disp("manual_idle", 1, 24'h000002, 0, 0);
    pulse_next();
    expect_disp("manual_1to3", 3, 24'h000004, 0, 1);
    pulse_next();
    expect_disp("manual_wrap", 1, 24'h000002, 0, 1);

    // Capture on the shown source shows up next cycle; others do not disturb.
    src_enable = 4'b1111;
    pulse_next();
    expect_disp("manual_1to2", 2, 24'h000003, 0, 1);
    src_value[48 +: 24] = 24'hABCDEF;
    src_valid = 4'b0100;
    step();
    expect_disp("cap_shown", 2, 24'hABCDEF, 0, 0);
    src_value[0 +: 24] = 24'h123456;
    src_valid = 4'b0001;
    step();
    expect_disp("cap_other", 2, 24'hABCDEF, 0, 0);
    src_valid = 4'b0000;

    // Freeze with a pending expiry, a capture and a pulse: nothing moves.
    mode_auto = 1'b1;
    step();
    step();
    step();
    expect_disp("pre_freeze", 2, 24'hABCDEF, 0, 0);
    freeze = 1'b1;
    src_value[48 +: 24] = 24'h111111;
    src_valid  = 4'b0100;
    next_pulse = 1'b1;
    step();
    expect_disp("frozen", 2, 24'hABCDEF, 0, 0);
    src_valid  = 4'b0000;
    next_pulse = 1'b0;
    step();
    step();
    expect_disp("frozen_hold", 2, 24'hABCDEF, 0, 0);
    // Count was held at DWELL-1, so the first unfrozen edge advances.
    freeze = 1'b0;
    step();
    expect_disp("unfreeze_adv", 3, 24'h000004, 0, 1);

    // Enable-driven moves, blanking and re-enable.
    mode_auto  = 1'b0;
    src_enable = 4'b0100;
    step();
    expect_disp("to_src2", 2, 24'hABCDEF, 0, 1);
    src_enable = 4'b0101;
    step();
    expect_disp("en_0101", 2, 24'hABCDEF, 0, 0);
    src_enable = 4'b0001;
    step();
    expect_disp("clear_cur", 0, 24'h123456, 0, 1);
    src_enable = 4'b0000;
    step();
    expect_disp("blank", 0, 24'h000000, 1, 0);
    src_enable = 4'b0100;
    step();
    expect_disp("reenable", 2, 24'hABCDEF, 0, 1);

    // Reset mid-dwell (count 2, sel 3), then a full dwell before the first advance.
    src_enable = 4'b1000;
    step();
    expect_disp("to_src3", 3, 24'h000004, 0, 1);
    src_enable = 4'b1111;
    mode_auto  = 1'b1;
    step();
    step();
    chk("mid_dwell.sel", 32'(disp_sel), 32'd3);
    rst = 1'b1;
    step();
    expect_disp("mid_rst", 0, 24'h000000, 1, 0);
    rst = 1'b0;
    step();
    expect_disp("post_rst", 0, 24'h000000, 0, 0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("post_rst_hold.sel", 32'(disp_sel), 32'd0);
      chk("post_rst_hold.new", 32'(disp_new), 32'd0);
    end
    step();
    expect_disp("post_rst_adv", 1, 24'h000000, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
